// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg: slot control type, fixed-point constants and parameter checks
// shared by escape_iter_engine and escape_step_stage.
package mandelbrot_pkg;

   // Per-slot bookkeeping flags; the data fields travel alongside.
   typedef struct packed {
      logic valid;
      logic done;
      logic esc;
   } slot_ctl_t;

   // |z|^2 escape bound (4.0); scaled by 2^(2*FRAC) at the product scale.
   localparam int ESCAPE_RADIUS_SQ = 4;

   function automatic bit int_bits_ok(input int width, input int frac);
      return (width - frac) >= 4;
   endfunction

   function automatic bit latency_ok(input int latency);
      return latency >= 2;
   endfunction

   function automatic bit iter_w_ok(input int max_iter, input int iter_w);
      return (max_iter >= 1) &&
             (longint'(max_iter) < (longint'(1) << iter_w));
   endfunction

endpackage

// File: rtl/escape_step_stage.sv
// escape_step_stage: escape test and z^2 + c step, LATENCY-1 register stages.
// Ports: in_* slot entering the pass, out_* slot after the pass (stepped,
// marked done, or passed through frozen).
module escape_step_stage
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 28,
   parameter int LATENCY  = 4,
   parameter int MAX_ITER = 255,
   parameter int ITER_W   = 8,
   parameter int TAG_W    = 16
)(
   input  logic              clock,
   input  logic              reset,
   input  slot_ctl_t         in_ctl,
   input  logic [WIDTH-1:0]  in_x,
   input  logic [WIDTH-1:0]  in_y,
   input  logic [WIDTH-1:0]  in_x0,
   input  logic [WIDTH-1:0]  in_y0,
   input  logic [ITER_W-1:0] in_iter,
   input  logic [TAG_W-1:0]  in_tag,
   output slot_ctl_t         out_ctl,
   output logic [WIDTH-1:0]  out_x,
   output logic [WIDTH-1:0]  out_y,
   output logic [WIDTH-1:0]  out_x0,
   output logic [WIDTH-1:0]  out_y0,
   output logic [ITER_W-1:0] out_iter,
   output logic [TAG_W-1:0]  out_tag
);

   localparam int PW = 2 * WIDTH;
   localparam logic [PW:0] RADIUS_Q =
      (PW+1)'(ESCAPE_RADIUS_SQ) << (2 * FRAC);
   localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

   typedef struct packed {
      slot_ctl_t         ctl;
      logic [WIDTH-1:0]  x;
      logic [WIDTH-1:0]  y;
      logic [WIDTH-1:0]  x0;
      logic [WIDTH-1:0]  y0;
      logic [ITER_W-1:0] iter;
      logic [TAG_W-1:0]  tag;
   } st_t;

   st_t in_s, fin_s, out_s;
   st_t p_slot_q, p_slot_d;

   logic signed [PW-1:0] xs, ys;
   logic signed [PW-1:0] xx_d, yy_d, xy_d;
   logic signed [PW-1:0] xx_q, yy_q, xy_q;
   logic [PW:0]          mag;
   logic signed [PW:0]   diff, dbl, diff_sh, dbl_sh;
   logic                 esc_hit;
   logic                 unused_bits;

   // First half: full-precision products of the current z.
   always_comb begin
      in_s = '{ctl: in_ctl, x: in_x, y: in_y, x0: in_x0,
               y0: in_y0, iter: in_iter, tag: in_tag};
      xs = PW'($signed(in_x));
      ys = PW'($signed(in_y));
      xx_d = xs * xs;
      yy_d = ys * ys;
      xy_d = xs * ys;
      p_slot_d = in_s;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         p_slot_q <= '0;
         xx_q     <= '0;
         yy_q     <= '0;
         xy_q     <= '0;
      end else begin
         p_slot_q <= p_slot_d;
         xx_q     <= xx_d;
         yy_q     <= yy_d;
         xy_q     <= xy_d;
      end
   end

   // Second half: escape decision, or floor-shift back to FRAC and add c.
   always_comb begin
      mag     = {1'b0, xx_q} + {1'b0, yy_q};
      esc_hit = mag > RADIUS_Q;
      diff    = {xx_q[PW-1], xx_q} - {yy_q[PW-1], yy_q};
      dbl     = {xy_q, 1'b0};
      diff_sh = diff >>> FRAC;
      dbl_sh  = dbl >>> FRAC;
      fin_s   = p_slot_q;
      if (p_slot_q.ctl.valid && !p_slot_q.ctl.done) begin
         if (esc_hit || (p_slot_q.iter == ITER_CAP)) begin
            fin_s.ctl.done = 1'b1;
            fin_s.ctl.esc  = esc_hit;
         end else begin
            fin_s.x    = diff_sh[WIDTH-1:0] + p_slot_q.x0;
            fin_s.y    = dbl_sh[WIDTH-1:0] + p_slot_q.y0;
            fin_s.iter = p_slot_q.iter + ITER_W'(1);
         end
      end
   end

   assign unused_bits = ^{diff_sh[PW:WIDTH], dbl_sh[PW:WIDTH]};

   if (LATENCY > 2) begin : g_dly
      st_t dly_q [LATENCY-2];
      st_t dly_d [LATENCY-2];

      always_comb begin
         dly_d[0] = fin_s;
         for (int i = 1; i < LATENCY - 2; i++) begin
            dly_d[i] = dly_q[i-1];
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < LATENCY - 2; i++) begin
               dly_q[i] <= '0;
            end
         end else begin
            dly_q <= dly_d;
         end
      end

      assign out_s = dly_q[LATENCY-3];
   end else begin : g_nodly
      assign out_s = fin_s;
   end

   assign out_ctl  = out_s.ctl;
   assign out_x    = out_s.x;
   assign out_y    = out_s.y;
   assign out_x0   = out_s.x0;
   assign out_y0   = out_s.y0;
   assign out_iter = out_s.iter;
   assign out_tag  = out_s.tag;

endmodule

// File: rtl/escape_iter_engine.sv
// escape_iter_engine: recirculating Mandelbrot escape-time engine with a
// LATENCY-slot job ring. Ports: clock, reset (async, active high); job input
// in_valid/in_ready, x0_in, y0_in, jobid_row_in, jobid_col_in; result output
// out_valid/out_ready, jobid_row_out, jobid_col_out, iter_out, escaped_out.
// Define ESCAPE_STATS_EN to add stat_jobs_done and stat_occupancy.
module escape_iter_engine
   import mandelbrot_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int FRAC     = 28,
   parameter int LATENCY  = 4,
   parameter int MAX_ITER = 255,
   parameter int ITER_W   = 8,
   parameter int ID_W     = 8
)(
   input  logic              clock,
   input  logic              reset,
`ifdef ESCAPE_STATS_EN
   output logic [31:0]       stat_jobs_done,
   output logic [$clog2(LATENCY+1)-1:0] stat_occupancy,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  x0_in,
   input  logic [WIDTH-1:0]  y0_in,
   input  logic [ID_W-1:0]   jobid_row_in,
   input  logic [ID_W-1:0]   jobid_col_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ID_W-1:0]   jobid_row_out,
   output logic [ID_W-1:0]   jobid_col_out,
   output logic [ITER_W-1:0] iter_out,
   output logic              escaped_out
);

   if (!int_bits_ok(WIDTH, FRAC) || !latency_ok(LATENCY) ||
       !iter_w_ok(MAX_ITER, ITER_W)) begin : g_param_err
      $error("escape_iter_engine: illegal parameter set");
   end

   typedef struct packed {
      slot_ctl_t         ctl;
      logic [WIDTH-1:0]  x;
      logic [WIDTH-1:0]  y;
      logic [WIDTH-1:0]  x0;
      logic [WIDTH-1:0]  y0;
      logic [ITER_W-1:0] iter;
      logic [2*ID_W-1:0] tag;
   } slot_t;

   slot_t head_q, head_d, inj;
   logic  xfer, accept;

   logic              out_valid_q, out_valid_d;
   logic [2*ID_W-1:0] out_tag_q, out_tag_d;
   logic [ITER_W-1:0] out_iter_q, out_iter_d;
   logic              out_esc_q, out_esc_d;

   // Head handling: a done job leaves only when the output register can
   // take it; the slot it frees is offered to the input in the same cycle.
   always_comb begin
      xfer = head_q.ctl.valid && head_q.ctl.done &&
             (!out_valid_q || out_ready);
      in_ready = !reset && (!head_q.ctl.valid || xfer);
      accept = in_valid && in_ready;
      inj = head_q;
      if (!head_q.ctl.valid || xfer) begin
         inj = '0;
         if (accept) begin
            inj.ctl.valid = 1'b1;
            inj.x0  = x0_in;
            inj.y0  = y0_in;
            inj.tag = {jobid_row_in, jobid_col_in};
         end
      end

      out_valid_d = out_valid_q;
      out_tag_d   = out_tag_q;
      out_iter_d  = out_iter_q;
      out_esc_d   = out_esc_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_tag_d   = head_q.tag;
         out_iter_d  = head_q.iter;
         out_esc_d   = head_q.ctl.esc;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   escape_step_stage #(
      .WIDTH    (WIDTH),
      .FRAC     (FRAC),
      .LATENCY  (LATENCY),
      .MAX_ITER (MAX_ITER),
      .ITER_W   (ITER_W),
      .TAG_W    (2 * ID_W)
   ) u_step (
      .clock    (clock),
      .reset    (reset),
      .in_ctl   (inj.ctl),
      .in_x     (inj.x),
      .in_y     (inj.y),
      .in_x0    (inj.x0),
      .in_y0    (inj.y0),
      .in_iter  (inj.iter),
      .in_tag   (inj.tag),
      .out_ctl  (head_d.ctl),
      .out_x    (head_d.x),
      .out_y    (head_d.y),
      .out_x0   (head_d.x0),
      .out_y0   (head_d.y0),
      .out_iter (head_d.iter),
      .out_tag  (head_d.tag)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q      <= '0;
         out_valid_q <= 1'b0;
         out_tag_q   <= '0;
         out_iter_q  <= '0;
         out_esc_q   <= 1'b0;
      end else begin
         head_q      <= head_d;
         out_valid_q <= out_valid_d;
         out_tag_q   <= out_tag_d;
         out_iter_q  <= out_iter_d;
         out_esc_q   <= out_esc_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign jobid_row_out = out_tag_q[2*ID_W-1:ID_W];
   assign jobid_col_out = out_tag_q[ID_W-1:0];
   assign iter_out      = out_iter_q;
   assign escaped_out   = out_esc_q;

`ifdef ESCAPE_STATS_EN
   localparam int OCC_W = $clog2(LATENCY + 1);

   logic [31:0]      jobs_q, jobs_d;
   logic [OCC_W-1:0] occ_q, occ_d;

   always_comb begin
      jobs_d = jobs_q;
      if (out_valid_q && out_ready) begin
         jobs_d = jobs_q + 32'd1;
      end
      occ_d = occ_q;
      if (accept && !xfer) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (xfer && !accept) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         jobs_q <= '0;
         occ_q  <= '0;
      end else begin
         jobs_q <= jobs_d;
         occ_q  <= occ_d;
      end
   end

   assign stat_jobs_done = jobs_q;
   assign stat_occupancy = occ_q;
`endif

endmodule

// File: tb/tb_escape_iter_engine.sv
// tb_escape_iter_engine: directed bench for escape_iter_engine (default
// parameters, Q4.28 inputs) with hand-computed expected results.
module tb_escape_iter_engine;

   localparam logic [31:0] FX_ZERO = 32'h0000_0000;
   localparam logic [31:0] FX_1P5  = 32'h1800_0000;
   localparam logic [31:0] FX_1P2  = 32'h1333_3333;
   localparam logic [31:0] FX_3P0  = 32'h3000_0000;
   localparam logic [31:0] FX_M2P0 = 32'hE000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x0_in, y0_in;
   logic [7:0]  jobid_row_in, jobid_col_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  jobid_row_out, jobid_col_out;
   logic [7:0]  iter_out;
   logic        escaped_out;

   int ntests;
   int nfail;

   escape_iter_engine dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .x0_in         (x0_in),
      .y0_in         (y0_in),
      .jobid_row_in  (jobid_row_in),
      .jobid_col_in  (jobid_col_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .jobid_row_out (jobid_row_out),
      .jobid_col_out (jobid_col_out),
      .iter_out      (iter_out),
      .escaped_out   (escaped_out)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic submit(input logic [31:0] x0, input logic [31:0] y0,
                         input logic [7:0] r, input logic [7:0] c);
      int n;
      n = 0;
      x0_in = x0;
      y0_in = y0;
      jobid_row_in = r;
      jobid_col_in = c;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      check($sformatf("accept_%0d", r), in_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input int budget, output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
      check("out_valid_timeout", out_valid, 1);
   endtask

   initial begin
      int n;
      int cnt;
      int bad;
      int idx;
      logic [4:0] seen;

      ntests = 0;
      nfail = 0;
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      x0_in = '0;
      y0_in = '0;
      jobid_row_in = '0;
      jobid_col_in = '0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_ids", {jobid_row_out, jobid_col_out}, 0);
      check("rst_iter_esc", {iter_out, escaped_out}, 0);
      reset = 1'b0;
      #1;
      check("in_ready_after_rst", in_ready, 1);
      @(posedge clock); #1;

      // c = 1.5 + 1.2i escapes after two steps.
      submit(FX_1P5, FX_1P2, 8'd42, 8'd24);
      wait_out(100, n);
      check("lat_c15_12", n + 1, 13);
      check("row_c15_12", jobid_row_out, 42);
      check("col_c15_12", jobid_col_out, 24);
      check("iter_c15_12", iter_out, 2);
      check("esc_c15_12", escaped_out, 1);
      @(posedge clock); #1;
      check("drained_c15_12", out_valid, 0);

      // (0,0) then (3,0): the later job finishes first.
      submit(FX_ZERO, FX_ZERO, 8'd1, 8'd1);
      submit(FX_3P0, FX_ZERO, 8'd3, 8'd0);
      wait_out(100, n);
      check("lat_c3", n + 1, 9);
      check("ooo_first_row", jobid_row_out, 3);
      check("ooo_first_col", jobid_col_out, 0);
      check("ooo_first_iter", iter_out, 1);
      check("ooo_first_esc", escaped_out, 1);
      @(posedge clock); #1;
      wait_out(1200, n);
      check("c0_ids", {jobid_row_out, jobid_col_out}, 16'h0101);
      check("c0_iter", iter_out, 255);
      check("c0_esc", escaped_out, 0);
      @(posedge clock); #1;

      // c = -2: |z|^2 == 4 exactly each step, strict compare never escapes.
      submit(FX_M2P0, FX_ZERO, 8'd7, 8'd9);
      wait_out(1200, n);
      check("m2_ids", {jobid_row_out, jobid_col_out}, 16'h0709);
      check("m2_iter", iter_out, 255);
      check("m2_esc", escaped_out, 0);
      @(posedge clock); #1;

      // Backpressure: fill the ring plus the output register.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         submit(FX_3P0, FX_ZERO, 8'(10 + i), 8'(50 + i));
      end
      for (int i = 0; i < 20; i++) begin
         check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
         check($sformatf("bp_hold_%0d", i),
               {out_valid, jobid_row_out, jobid_col_out,
                iter_out, escaped_out},
               {1'b1, 8'd10, 8'd50, 8'd1, 1'b1});
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      cnt = 0;
      bad = 0;
      seen = '0;
      for (int i = 0; i < 100; i++) begin
         if (out_valid === 1'b1) begin
            cnt++;
            idx = int'(jobid_row_out) - 10;
            if (idx >= 0 && idx < 5 &&
                int'(jobid_col_out) == 50 + idx &&
                iter_out == 8'd1 && escaped_out == 1'b1) begin
               seen[idx] = 1'b1;
            end else begin
               bad++;
            end
         end
         @(posedge clock); #1;
      end
      check("bp_count", cnt, 5);
      check("bp_seen", seen, 5'h1f);
      check("bp_bad", bad, 0);

      // Reset with jobs in flight and a result held in the output register.
      out_ready = 1'b0;
      submit(FX_3P0, FX_ZERO, 8'd30, 8'd0);
      submit(FX_ZERO, FX_ZERO, 8'd20, 8'd0);
      submit(FX_ZERO, FX_ZERO, 8'd21, 8'd0);
      wait_out(50, n);
      check("pre_rst_row", jobid_row_out, 30);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_ids", {jobid_row_out, jobid_col_out}, 0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);
      @(posedge clock); #1;
      out_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 1200; i++) begin
         if (out_valid === 1'b1) cnt++;
         @(posedge clock); #1;
      end
      check("no_stale_results", cnt, 0);

      submit(FX_3P0, FX_ZERO, 8'd99, 8'd98);
      wait_out(100, n);
      check("post_rst_job", {jobid_row_out, jobid_col_out, iter_out},
            {8'd99, 8'd98, 8'd1});

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
